pc_seq: RTL and testbench

PC_SEQ -- requirements
Module: pc_seq

---
 rtl/pc_seq.sv | 176 +++++++++++++++++
 tb/tb_pc_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq -- program counter sequencer with a return-address stack and a
// RUN/HALT control state.
//
// The pc is a plain register that drives the program memory address directly.
// On every enabled cycle in RUN it advances by exactly one of these actions,
// highest priority first: enter HALT, return, call, branch, increment.
//
// Ports:
//   clk       in   rising-edge clock for all state
//   reset     in   synchronous, active-high; overrides every other input
//   en        in   advance enable in RUN (0 = stall, requests dropped)
//   branch    in   jump request; rel selects relative (pc+target) or absolute
//   rel       in   qualifies branch
//   call      in   push pc+1 and jump to target (absolute)
//   ret       in   pop the return address into pc
//   target    in   [P_SIZE] jump/call target, two's-complement offset if rel
//   halt_req  in   enter HALT (pc and stack held)
//   resume    in   leave HALT, unless halt_req is also asserted
//   pc        out  [P_SIZE] registered program counter
//   halted    out  1 while in HALT; this is the state register made visible
//   ovf       out  sticky: call attempted with the stack full
//   unf       out  sticky: ret attempted with the stack empty
// -----------------------------------------------------------------------------
module pc_seq #(
    parameter int P_SIZE  = 6,
    parameter int S_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              branch,
    input  logic              rel,
    input  logic              call,
    input  logic              ret,
    input  logic [P_SIZE-1:0] target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [P_SIZE-1:0] pc,
    output logic              halted,
    output logic              ovf,
    output logic              unf
);

    // The stack pointer counts entries, so it needs to hold 0..S_DEPTH.
    localparam int SP_W = $clog2(S_DEPTH + 1);

    localparam logic [P_SIZE-1:0] PC_ONE = {{(P_SIZE-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   SP_ONE = {{(SP_W-1){1'b0}}, 1'b1};
    localparam logic [SP_W-1:0]   SP_FULL = SP_W'(S_DEPTH);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [P_SIZE-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [P_SIZE-1:0] stack_q [S_DEPTH];
    logic [P_SIZE-1:0] stack_d [S_DEPTH];

    logic [P_SIZE-1:0] pc_inc;
    logic [SP_W-1:0]   sp_top;
    logic [P_SIZE-1:0] top_val;
    logic              stk_empty;
    logic              stk_full;
    logic              do_push;

    assign pc_inc    = pc_q + PC_ONE;
    assign sp_top    = sp_q - SP_ONE;
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_FULL);

    // Read of the top entry. Only used when the stack is non-empty, so the
    // wrapped sp_top seen on an empty stack never reaches the pc.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < S_DEPTH; i++) begin
            if (SP_W'(i) == sp_top) begin
                top_val = stack_q[i];
            end
        end
    end

    // Next-state / next-pc selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        do_push = 1'b0;

        case (state_q)
            S_RUN: begin
                if (en) begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (ret) begin
                        if (!stk_empty) begin
                            pc_d = top_val;
                            sp_d = sp_top;
                        end else begin
                            unf_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    end else if (call) begin
                        if (!stk_full) begin
                            do_push = 1'b1;
                            sp_d    = sp_q + SP_ONE;
                            pc_d    = target;
                        end else begin
                            ovf_d = 1'b1;
                            pc_d  = pc_inc;
                        end
                    end else if (branch) begin
                        // A P_SIZE-bit add wraps modulo 2^P_SIZE, which is the
                        // same result as adding the sign-extended offset and
                        // truncating, so no explicit extension is needed.
                        pc_d = rel ? (pc_q + target) : target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALT: begin
                if (resume && !halt_req) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Stack write: the pushed return address lands in slot sp_q.
    always_comb begin
        stack_d = stack_q;
        for (int i = 0; i < S_DEPTH; i++) begin
            if (do_push && (SP_W'(i) == sp_q)) begin
                stack_d[i] = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are left unreset: an empty pop never reads them.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);
    assign ovf    = ovf_q;
    assign unf    = unf_q;

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq -- self-checking bench for pc_seq (P_SIZE=6, S_DEPTH=4).
//
// A behavioural model (integer pc, queue as the return stack) is stepped on
// every clock edge with the same inputs as the DUT; a compare process checks
// all outputs against it on every falling edge. Directed sequences add
// hand-computed literal checks that pin the model itself.
// -----------------------------------------------------------------------------
module tb_pc_seq;

    localparam int P_SIZE  = 6;
    localparam int S_DEPTH = 4;
    localparam int PC_MOD  = 1 << P_SIZE;

    // Clock / reset / stimulus signals
    logic              clk;
    logic              reset;
    logic              en;
    logic              branch;
    logic              rel;
    logic              call;
    logic              ret;
    logic [P_SIZE-1:0] target;
    logic              halt_req;
    logic              resume;
    logic [P_SIZE-1:0] pc;
    logic              halted;
    logic              ovf;
    logic              unf;

    pc_seq #(
        .P_SIZE  (P_SIZE),
        .S_DEPTH (S_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .branch   (branch),
        .rel      (rel),
        .call     (call),
        .ret      (ret),
        .target   (target),
        .halt_req (halt_req),
        .resume   (resume),
        .pc       (pc),
        .halted   (halted),
        .ovf      (ovf),
        .unf      (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counters
    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int                m_pc   = 0;
    bit                m_halt = 1'b0;
    bit                m_ovf  = 1'b0;
    bit                m_unf  = 1'b0;
    logic [P_SIZE-1:0] m_stk[$];

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: one clock edge of the sequencer, straight from the behaviour rules.
    task automatic model_step(input bit r, input bit e, input bit b, input bit rl,
                              input bit c, input bit rt, input int t,
                              input bit h, input bit rs);
        int off;
        if (r) begin
            m_pc   = 0;
            m_halt = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_stk.delete();
        end else if (m_halt) begin
            if (rs && !h) m_halt = 1'b0;
        end else if (e) begin
            if (h) begin
                m_halt = 1'b1;
            end else if (rt) begin
                if (m_stk.size() > 0) begin
                    m_pc = int'(m_stk.pop_back());
                end else begin
                    m_unf = 1'b1;
                    m_pc  = (m_pc + 1) % PC_MOD;
                end
            end else if (c) begin
                if (m_stk.size() < S_DEPTH) begin
                    m_stk.push_back(P_SIZE'((m_pc + 1) % PC_MOD));
                    m_pc = t;
                end else begin
                    m_ovf = 1'b1;
                    m_pc  = (m_pc + 1) % PC_MOD;
                end
            end else if (b) begin
                if (rl) begin
                    off  = (t >= PC_MOD / 2) ? t - PC_MOD : t;
                    m_pc = (((m_pc + off) % PC_MOD) + PC_MOD) % PC_MOD;
                end else begin
                    m_pc = t;
                end
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    // Compare process: every falling edge, DUT vs model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("pc", int'(pc), m_pc);
            cmp("halted", int'(halted), int'(m_halt));
            cmp("ovf", int'(ovf), int'(m_ovf));
            cmp("unf", int'(unf), int'(m_unf));
        end
    end

    // Driver: present inputs, let one rising edge happen, advance the model,
    // then return at the falling edge where outputs are compared.
    task automatic apply(input bit r, input bit e, input bit b, input bit rl,
                         input bit c, input bit rt, input int t,
                         input bit h, input bit rs);
        reset    = r;
        en       = e;
        branch   = b;
        rel      = rl;
        call     = c;
        ret      = rt;
        target   = P_SIZE'(t);
        halt_req = h;
        resume   = rs;
        @(posedge clk);
        model_step(r, e, b, rl, c, rt, t, h, rs);
        @(negedge clk);
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jmp(input int t);
        apply(0, 1, 1, 0, 0, 0, t, 0, 0);
    endtask

    task automatic do_call(input int t);
        apply(0, 1, 0, 0, 1, 0, t, 0, 0);
    endtask

    task automatic do_ret();
        apply(0, 1, 0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; branch = 1'b0; rel = 1'b0; call = 1'b0;
        ret = 1'b0; target = '0; halt_req = 1'b0; resume = 1'b0;
        chk_en = 1'b1;

        // Reset state, with a pending call and halt_req that must be overridden
        apply(1, 1, 0, 0, 1, 0, 33, 1, 0);
        cmp("lit_reset_pc", int'(pc), 0);
        cmp("lit_reset_halted", int'(halted), 0);

        // Free-running count with wrap: 70 edges -> 6
        idle(70);
        cmp("lit_wrap_pc", int'(pc), 6);

        // Call / return pair
        do_reset();
        idle(10);
        do_call(40);
        cmp("lit_call_pc", int'(pc), 40);
        do_ret();
        cmp("lit_ret_pc", int'(pc), 11);
        cmp("lit_callret_ovf", int'(ovf), 0);
        cmp("lit_callret_unf", int'(unf), 0);

        // Overflow and underflow around a depth-4 stack
        do_reset();
        for (int i = 0; i < 4; i++) do_call(20);
        cmp("lit_call4_pc", int'(pc), 20);
        do_call(20);
        cmp("lit_call5_pc", int'(pc), 21);
        cmp("lit_call5_ovf", int'(ovf), 1);
        do_ret();
        cmp("lit_ret1_pc", int'(pc), 21);
        do_ret();
        do_ret();
        cmp("lit_ret3_pc", int'(pc), 21);
        do_ret();
        cmp("lit_ret4_pc", int'(pc), 1);
        cmp("lit_ret4_unf", int'(unf), 0);
        do_ret();
        cmp("lit_ret5_pc", int'(pc), 2);
        cmp("lit_ret5_unf", int'(unf), 1);
        cmp("lit_ovf_sticky", int'(ovf), 1);

        // Relative branches, both directions, with wrap
        do_reset();
        idle(2);
        apply(0, 1, 1, 1, 0, 0, 6'b111110, 0, 0);
        cmp("lit_rel_back_pc", int'(pc), 0);
        jmp(62);
        cmp("lit_abs_pc", int'(pc), 62);
        apply(0, 1, 1, 1, 0, 0, 5, 0, 0);
        cmp("lit_rel_wrap_pc", int'(pc), 3);

        // Priority: ret beats call and branch
        do_reset();
        do_call(30);
        apply(0, 1, 1, 0, 1, 1, 50, 0, 0);
        cmp("lit_ret_prio_pc", int'(pc), 1);

        // HALT behaviour
        do_reset();
        jmp(7);
        apply(0, 1, 1, 0, 0, 0, 0, 1, 0);
        cmp("lit_halt_halted", int'(halted), 1);
        for (int i = 0; i < 5; i++) apply(0, 1, 1, i[0], i[1], i[2], 33, 0, 0);
        cmp("lit_halt_pc", int'(pc), 7);
        apply(0, 1, 0, 0, 0, 0, 0, 1, 1);
        cmp("lit_resume_blocked", int'(halted), 1);
        apply(0, 1, 0, 0, 0, 0, 0, 0, 1);
        cmp("lit_resume_halted", int'(halted), 0);
        cmp("lit_resume_pc", int'(pc), 7);
        idle(1);
        cmp("lit_after_resume_pc", int'(pc), 8);

        // Stall: requests dropped, stack stays empty
        do_reset();
        jmp(5);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 0, 40, 0, 0);
        cmp("lit_stall_pc", int'(pc), 5);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cmp("lit_stall_nohalt", int'(halted), 0);
        do_ret();
        cmp("lit_stall_empty_unf", int'(unf), 1);
        cmp("lit_stall_empty_pc", int'(pc), 6);
        apply(0, 1, 0, 0, 0, 0, 0, 1, 0);
        apply(1, 1, 0, 0, 1, 0, 9, 1, 0);
        cmp("lit_rst_halt_pc", int'(pc), 0);
        cmp("lit_rst_halt_halted", int'(halted), 0);
        cmp("lit_rst_halt_unf", int'(unf), 0);

        // Mixed pseudo-random traffic checked against the model
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, PC_MOD - 1),
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) == 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
